// File: rtl/ram_fifo_ctrl.sv
// Circular-queue controller for one single-port RAM: arbitrates push and pop
// onto the shared addr/rw port, one access per cycle, round-robin on conflict.
//
// Arbitration state (last_grant):
//   state      | meaning
//   GRANT_POP  | last conflict went to pop (reset value); next conflict -> push
//   GRANT_PUSH | last conflict went to push; next conflict -> pop
module ram_fifo_ctrl #(
   parameter int AW        = 3,
   parameter int DW        = 4,
   parameter int AFULL_TH  = 6,
   parameter int AEMPTY_TH = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_valid,
   input  logic [DW-1:0] push_data,
   output logic          push_ready,
   input  logic          pop_req,
   output logic          pop_grant,
   output logic [DW-1:0] pop_data,
   output logic          pop_valid,
   output logic [AW-1:0] ram_addr,
   output logic          ram_rw,
   output logic [DW-1:0] ram_data_in,
   input  logic [DW-1:0] ram_data_out,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          almost_full,
   output logic          almost_empty
);

   typedef enum logic {
      GRANT_POP  = 1'b0,
      GRANT_PUSH = 1'b1
   } grant_t;

   localparam logic [AW:0] DEPTH      = (AW+1)'(2**AW);
   localparam logic [AW:0] AFULL_LVL  = (AW+1)'(AFULL_TH);
   localparam logic [AW:0] AEMPTY_LVL = (AW+1)'(AEMPTY_TH);

   grant_t        last_grant;
   grant_t        last_grant_nxt;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_elig;
   logic          pop_elig;
   logic          push_do;
   logic          pop_do;

   assign full         = (count == DEPTH);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AFULL_LVL);
   assign almost_empty = (count <= AEMPTY_LVL);

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= GRANT_POP;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         pop_valid  <= 1'b0;
         pop_data   <= '0;
      end else begin
         last_grant <= last_grant_nxt;
         pop_valid  <= pop_do;
         if (push_do) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count + 1'b1;
         end else if (pop_do) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
         end
         if (pop_do) begin
            pop_data <= ram_data_out;
         end
      end
   end

   always_comb begin
      push_elig      = push_valid & ~full;
      pop_elig       = pop_req & ~empty;
      push_ready     = ~reset & ~full & (~pop_elig | (last_grant == GRANT_POP));
      pop_grant      = ~reset & ~empty & (~push_elig | (last_grant == GRANT_PUSH));
      push_do        = push_valid & push_ready;
      pop_do         = pop_req & pop_grant;
      last_grant_nxt = last_grant;
      ram_rw         = 1'b0;
      ram_addr       = rd_ptr;
      ram_data_in    = '0;

      // Only a real conflict moves the round-robin pointer.
      if (push_elig && pop_elig && !reset) begin
         last_grant_nxt = push_do ? GRANT_PUSH : GRANT_POP;
      end

      if (push_do) begin
         ram_rw      = 1'b1;
         ram_addr    = wr_ptr;
         ram_data_in = push_data;
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural single-port RAM
// (synchronous write, combinational read) attached to the RAM port.
module tb_ram_fifo_ctrl;

   localparam int AW = 3;
   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          push_valid;
   logic [DW-1:0] push_data;
   logic          push_ready;
   logic          pop_req;
   logic          pop_grant;
   logic [DW-1:0] pop_data;
   logic          pop_valid;
   logic [AW-1:0] ram_addr;
   logic          ram_rw;
   logic [DW-1:0] ram_data_in;
   logic [DW-1:0] ram_data_out;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;

   logic [DW-1:0] mem [2**AW];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_rw) mem[ram_addr] <= ram_data_in;
   end
   assign ram_data_out = mem[ram_addr];

   ram_fifo_ctrl #(.AW(AW), .DW(DW), .AFULL_TH(6), .AEMPTY_TH(1)) dut (
      .clk          (clk),
      .reset        (reset),
      .push_valid   (push_valid),
      .push_data    (push_data),
      .push_ready   (push_ready),
      .pop_req      (pop_req),
      .pop_grant    (pop_grant),
      .pop_data     (pop_data),
      .pop_valid    (pop_valid),
      .ram_addr     (ram_addr),
      .ram_rw       (ram_rw),
      .ram_data_in  (ram_data_in),
      .ram_data_out (ram_data_out),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [DW-1:0] d);
      push_valid = 1'b1;
      push_data  = d;
      pop_req    = 1'b0;
      @(negedge clk);
      chk("push_ready", push_ready, 1);
      tick();
      push_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 2**AW; i++) mem[i] = '0;
      reset      = 1'b1;
      push_valid = 1'b1;
      push_data  = 4'h5;
      pop_req    = 1'b1;

      // Reset
      tick();
      tick();
      @(negedge clk);
      chk("rst_push_ready", push_ready, 0);
      chk("rst_pop_grant", pop_grant, 0);
      chk("rst_ram_rw", ram_rw, 0);
      tick();
      reset      = 1'b0;
      push_valid = 1'b0;
      pop_req    = 1'b0;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_pop_valid", pop_valid, 0);
      chk("rst_aempty", almost_empty, 1);
      @(negedge clk);
      chk("idle_ram_rw", ram_rw, 0);
      tick();

      // Fill to full
      for (int i = 1; i <= 8; i++) begin
         push_valid = 1'b1;
         push_data  = DW'(i);
         @(negedge clk);
         chk("fill_ready", push_ready, 1);
         chk("fill_rw", ram_rw, 1);
         chk("fill_addr", ram_addr, i - 1);
         chk("fill_count", count, i - 1);
         chk("fill_afull", almost_full, (i - 1) >= 6);
         tick();
      end
      chk("full_count", count, 8);
      chk("full_flag", full, 1);
      chk("full_afull", almost_full, 1);
      push_data = 4'h9;
      @(negedge clk);
      chk("ovf_ready", push_ready, 0);
      chk("ovf_rw", ram_rw, 0);
      tick();
      push_valid = 1'b0;
      chk("ovf_count", count, 8);

      // Drain
      for (int i = 1; i <= 8; i++) begin
         pop_req = 1'b1;
         @(negedge clk);
         chk("drain_grant", pop_grant, 1);
         chk("drain_addr", ram_addr, i - 1);
         chk("drain_rw", ram_rw, 0);
         tick();
         chk("drain_valid", pop_valid, 1);
         chk("drain_data", pop_data, i);
      end
      chk("drain_empty", empty, 1);
      @(negedge clk);
      chk("udf_grant", pop_grant, 0);
      tick();
      pop_req = 1'b0;
      chk("udf_valid", pop_valid, 0);
      chk("udf_count", count, 0);
      chk("udf_data_hold", pop_data, 8);

      // Round-robin under conflict
      reset = 1'b1;
      tick();
      reset = 1'b0;
      push_one(4'hA);
      push_one(4'hB);
      push_one(4'hC);
      push_one(4'hD);
      chk("rr_count0", count, 4);
      begin
         logic [3:0]    exp_push;
         logic [DW-1:0] nxt_push;
         logic [DW-1:0] nxt_pop;
         logic [AW:0]   exp_cnt;
         exp_push = 4'b0101;
         nxt_push = 4'hE;
         nxt_pop  = 4'hA;
         exp_cnt  = 4;
         for (int c = 0; c < 4; c++) begin
            push_valid = 1'b1;
            pop_req    = 1'b1;
            push_data  = nxt_push;
            @(negedge clk);
            chk("rr_push_ready", push_ready, exp_push[c]);
            chk("rr_pop_grant", pop_grant, !exp_push[c]);
            tick();
            if (exp_push[c]) begin
               nxt_push = nxt_push + 1'b1;
               exp_cnt  = exp_cnt + 1'b1;
               chk("rr_no_popv", pop_valid, 0);
            end else begin
               exp_cnt  = exp_cnt - 1'b1;
               chk("rr_popv", pop_valid, 1);
               chk("rr_pop_data", pop_data, nxt_pop);
               nxt_pop = nxt_pop + 1'b1;
            end
            chk("rr_count", count, exp_cnt);
         end
      end
      push_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pop_req = 1'b1;
         tick();
         chk("rr_tail_data", pop_data, 4'hC + i);
      end
      pop_req = 1'b0;
      chk("rr_tail_empty", empty, 1);

      // Pointer wrap with interleaved push/pop
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         push_valid = 1'b1;
         push_data  = DW'(i);
         @(negedge clk);
         chk("wrap_waddr", ram_addr, i % 8);
         tick();
         push_valid = 1'b0;
         pop_req    = 1'b1;
         @(negedge clk);
         chk("wrap_grant", pop_grant, 1);
         tick();
         pop_req = 1'b0;
         chk("wrap_data", pop_data, i % 16);
      end

      // Reset during a pop grant
      reset = 1'b1;
      tick();
      reset = 1'b0;
      push_one(4'h5);
      push_one(4'h6);
      push_one(4'h7);
      push_one(4'h8);
      pop_req = 1'b1;
      tick();
      chk("mid_pre_data", pop_data, 5);
      chk("mid_pre_count", count, 3);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_grant", pop_grant, 0);
      tick();
      reset   = 1'b0;
      pop_req = 1'b0;
      chk("mid_pop_valid", pop_valid, 0);
      chk("mid_pop_data", pop_data, 0);
      chk("mid_count", count, 0);
      chk("mid_empty", empty, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
